// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ADD,
        SHIFT,
        DONE
    } mult_state_t;

    // Extension bit placed above an operand's MSB: copies the MSB for
    // two's-complement operands, zero for unsigned ones.
    function automatic logic ext(input logic msb, input logic sgn);
        return msb & sgn;
    endfunction

endpackage

// File: rtl/add_sub_unit.sv
// Ripple-carry adder/subtractor; subtract is A + ~B + 1 with Sub as carry-in.
module add_sub_unit #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic [WIDTH-1:0] Sum
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] c;

    assign bx   = B ^ {WIDTH{Sub}};
    assign c[0] = Sub;

    // One full adder per bit; the carry out of the top bit is not needed.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            assign Sum[i] = A[i] ^ bx[i] ^ c[i];
            if (i < WIDTH - 1) begin : g_c
                assign c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
            end
        end
    endgenerate

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier: {A,B} <= B * S over WIDTH add/shift pairs.
// Signed mode subtracts on the last step (MSB of a two's-complement
// multiplier has negative weight); unsigned mode keeps the carry in X.
module seq_mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Busy,
    output logic             Done
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mult_state_t state, nxt;

    logic [WIDTH-1:0] a_q, b_q, s_q;
    logic             x_q;
    logic [CW-1:0]    cnt_q;

    logic do_load, do_clr, do_add, do_shift;
    logic sub;
    logic [WIDTH:0] sum;

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state and datapath control strobes.
    always_comb begin
        nxt      = state;
        do_load  = 1'b0;
        do_clr   = 1'b0;
        do_add   = 1'b0;
        do_shift = 1'b0;
        case (state)
            IDLE: begin
                if (ClearA_LoadB) do_load = 1'b1;
                else if (Run)     nxt = CLR;
            end
            CLR: begin
                do_clr = 1'b1;
                nxt    = ADD;
            end
            ADD: begin
                do_add = 1'b1;
                nxt    = SHIFT;
            end
            SHIFT: begin
                do_shift = 1'b1;
                nxt      = (cnt_q == LAST) ? DONE : ADD;
            end
            DONE: begin
                // Run must drop before another multiply can start.
                if (!Run) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign sub = b_q[0] && (cnt_q == LAST) && (SIGNED != 1'b0);

    add_sub_unit #(.WIDTH(WIDTH + 1)) u_add_sub (
        .A   ({ext(a_q[WIDTH-1], SIGNED), a_q}),
        .B   ({ext(s_q[WIDTH-1], SIGNED), s_q}),
        .Sub (sub),
        .Sum (sum)
    );

    // X/A/B/S/count registers; B is never cleared by CLR so a previous
    // product's low half can serve as the next multiplier.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            x_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (do_load) begin
                a_q <= '0;
                x_q <= 1'b0;
                b_q <= Din;
            end
            if (do_clr) begin
                a_q   <= '0;
                x_q   <= 1'b0;
                s_q   <= Din;
                cnt_q <= '0;
            end
            if (do_add && b_q[0]) begin
                {x_q, a_q} <= sum;
            end
            if (do_shift) begin
                a_q   <= {x_q, a_q[WIDTH-1:1]};
                b_q   <= {a_q[0], b_q[WIDTH-1:1]};
                x_q   <= SIGNED ? x_q : 1'b0;
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign Xval = x_q;
    assign Busy = (state == CLR) || (state == ADD) || (state == SHIFT);
    assign Done = (state == DONE);

endmodule

// File: tb/tb_seq_mult_unit.sv
// Bench for seq_mult_unit: a signed and an unsigned instance share the
// inputs; each product is compared against integer multiplication.
module tb_seq_mult_unit;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Run = 1'b0;
    logic         ClearA_LoadB = 1'b0;
    logic [W-1:0] Din = '0;

    logic [W-1:0] sg_a, sg_b, us_a, us_b;
    logic         sg_x, sg_busy, sg_done, us_x, us_busy, us_done;

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] cur_b = '0;   // multiplier the DUTs currently hold in B

    always #5 Clk = ~Clk;

    seq_mult_unit #(.WIDTH(W), .SIGNED(1'b1)) u_sg (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .Din(Din),
        .Aval(sg_a), .Bval(sg_b), .Xval(sg_x), .Busy(sg_busy), .Done(sg_done)
    );

    seq_mult_unit #(.WIDTH(W), .SIGNED(1'b0)) u_us (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .Din(Din),
        .Aval(us_a), .Bval(us_b), .Xval(us_x), .Busy(us_busy), .Done(us_done)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " sg_a"}, 16'(sg_a), 16'h0);
        chk({tag, " sg_b"}, 16'(sg_b), 16'h0);
        chk({tag, " sg_x"}, 16'(sg_x), 16'h0);
        chk({tag, " sg_bd"}, {14'h0, sg_busy, sg_done}, 16'h0);
        chk({tag, " us_a"}, 16'(us_a), 16'h0);
        chk({tag, " us_b"}, 16'(us_b), 16'h0);
        chk({tag, " us_x"}, 16'(us_x), 16'h0);
        chk({tag, " us_bd"}, {14'h0, us_busy, us_done}, 16'h0);
    endtask

    task automatic load(input logic [W-1:0] b);
        ClearA_LoadB = 1'b1;
        Run = 1'b0;
        Din = b;
        step();
        ClearA_LoadB = 1'b0;
        chk("load sg_ab", {sg_a, sg_b}, {8'h00, b});
        chk("load us_ab", {us_a, us_b}, {8'h00, b});
        chk("load x", {14'h0, sg_x, us_x}, 16'h0);
        chk("load busy", {14'h0, sg_busy, us_busy}, 16'h0);
        cur_b = b;
    endtask

    // Multiply the held B by s; Din and ClearA_LoadB are scrambled while busy.
    task automatic run_mult(input logic [W-1:0] s, input int hold);
        int sp, up;
        logic [15:0] es, eu;
        sp = int'($signed(cur_b)) * int'($signed(s));
        up = int'(cur_b) * int'(s);
        es = sp[15:0];
        eu = up[15:0];

        ClearA_LoadB = 1'b0;
        Run = 1'b1;
        Din = s;
        step();
        chk("start busy", {14'h0, sg_busy, us_busy}, 16'h3);
        for (int k = 1; k <= 2 * W; k++) begin
            if (k > 1) begin
                Din = W'($urandom);
                ClearA_LoadB = 1'($urandom);
            end
            step();
            chk("busy run", {12'h0, sg_busy, us_busy, sg_done, us_done}, 16'hC);
        end
        ClearA_LoadB = 1'b0;
        step();
        chk("done flag", {12'h0, sg_busy, us_busy, sg_done, us_done}, 16'h3);
        chk("sg prod", {sg_a, sg_b}, es);
        chk("sg x", 16'(sg_x), 16'(es[15]));
        chk("us prod", {us_a, us_b}, eu);
        chk("us x", 16'(us_x), 16'h0);
        for (int k = 0; k < hold; k++) begin
            Din = W'($urandom);
            step();
            chk("hold done", {12'h0, sg_busy, us_busy, sg_done, us_done}, 16'h3);
        end
        if (hold > 0) begin
            chk("hold sg prod", {sg_a, sg_b}, es);
            chk("hold us prod", {us_a, us_b}, eu);
        end
        Run = 1'b0;
        step();
        chk("idle flags", {12'h0, sg_busy, us_busy, sg_done, us_done}, 16'h0);
        chk("idle sg prod", {sg_a, sg_b}, es);
        cur_b = es[7:0];
    endtask

    initial begin
        // Reset state
        #2;
        chk_zero("reset");
        step();
        Reset = 1'b1;
        step();
        chk_zero("post reset");

        // 59 * 7 = 413
        load(8'h3B);
        run_mult(8'h07, 0);
        chk("t1 sg", {7'h0, sg_x, sg_a, sg_b}, 16'h019D);

        // 59 * -7 = -413
        load(8'h3B);
        run_mult(8'hF9, 0);
        chk("t2 sg", {7'h0, sg_x, sg_a, sg_b}, {7'h0, 1'b1, 8'hFE, 8'h63});

        // chained: -99 * 3 = -297
        load(8'h3B);
        run_mult(8'h07, 0);
        run_mult(8'h03, 0);
        chk("t3 sg", {7'h0, sg_x, sg_a, sg_b}, {7'h0, 1'b1, 8'hFE, 8'hD7});

        // min * min, and multiply by zero
        load(8'h80);
        run_mult(8'h80, 0);
        chk("t4 sg", {7'h0, sg_x, sg_a, sg_b}, 16'h4000);
        load(8'h80);
        run_mult(8'h00, 0);
        chk("t4 zero", {sg_a, sg_b}, 16'h0000);

        // 255 * 255 unsigned with Run held for 40 cycles
        load(8'hFF);
        run_mult(8'hFF, 40);
        chk("t5 us", {7'h0, us_x, us_a, us_b}, 16'hFE01);

        // ClearA_LoadB together with Run in IDLE only loads
        ClearA_LoadB = 1'b1;
        Run = 1'b1;
        Din = 8'h5A;
        step();
        step();
        chk("load+run busy", {12'h0, sg_busy, us_busy, sg_done, us_done}, 16'h0);
        chk("load+run b", {sg_b, us_b}, 16'h5A5A);
        ClearA_LoadB = 1'b0;
        Run = 1'b0;
        step();
        cur_b = 8'h5A;

        // Random operands, mixing fresh loads with chained multiplies
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) != 0) load(W'($urandom));
            run_mult(W'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset asserted during the fifth ADD
        load(8'h55);
        Run = 1'b1;
        Din = 8'h33;
        step();
        for (int k = 0; k < 9; k++) step();
        chk("pre-abort busy", {14'h0, sg_busy, us_busy}, 16'h3);
        Reset = 1'b0;
        #1;
        chk_zero("abort");
        Run = 1'b0;
        step();
        Reset = 1'b1;
        step();
        chk_zero("after abort");
        cur_b = '0;

        // Machine is usable again after the abort
        load(8'hC3);
        run_mult(8'h5E, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL timeout n_chk=%0d required=finish", n_chk);
        $fatal(1, "timeout");
    end

endmodule
